mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one single-port memory bus between the fetch stage (inst side) and the
//  mem stage (data side, lw/sw from mem_sel). Runs a request/addr_ok/data_ok
//  handshake with the bus, returns stall signals that feed hazard, and drops
//  fetch results invalidated by an exception flush. Data side has fixed priority;
//  an in-flight transaction is never pre-empted.
// PARAMETERS
//  AW  32  address width
//  DW  32  data width (DW/8 byte selects)
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     reset, asynchronous, active-low
//  inst_req     in   1     fetch wants word at inst_addr (held until !inst_stall)
//  inst_addr    in   AW    fetch address (pcF)
//  inst_rdata   out  DW    fetched word, valid when inst_req & !inst_stall
//  inst_stall   out  1     fetch must hold
//  data_req     in   1     mem stage access (held until !data_stall)
//  data_wr      in   1     1=store, 0=load
//  data_sel     in   DW/8  byte enables (sel)
//  data_addr    in   AW    aluoutM
//  data_wdata   in   DW    writedata2M
//  data_rdata   out  DW    load data, valid when data_req & !data_stall
//  data_stall   out  1     mem stage must hold
//  flush        in   1     exception flush; cancels pending fetch result
//  bus_req      out  1     bus request
//  bus_wr       out  1     bus write
//  bus_sel      out  DW/8  bus byte enables
//  bus_addr     out  AW    bus address
//  bus_wdata    out  DW    bus write data
//  bus_addr_ok  in   1     bus accepted address (request retires)
//  bus_data_ok  in   1     bus read data valid / write done
//  bus_rdata    in   DW    bus read data
// BEHAVIOUR
//  Reset (rst=0, any time, async): state=IDLE; bus_req, bus_wr, bus_sel, bus_addr,
//   bus_wdata, inst_rdata, data_rdata, done pulses, discard flag all 0. Stalls
//   follow their combinational equations (high if the matching req is high).
//  States: IDLE, DREQ, DWAIT, IREQ, IWAIT.
//  IDLE: an eligible data_req -> DREQ, else an eligible inst_req -> IREQ; latch
//   addr/wr/sel/wdata into bus_* regs (inst side: bus_wr=0, bus_sel=all ones).
//   A side is not eligible in the cycle its done pulse is high.
//  DREQ/IREQ: bus_req=1, bus_* held stable; bus_addr_ok=1 -> DWAIT/IWAIT, bus_req
//   deasserts next cycle. bus_req is never withdrawn before addr_ok.
//  DWAIT/IWAIT: bus_req=0; bus_data_ok=1 -> IDLE; capture bus_rdata into
//   data_rdata/inst_rdata; set d_done/i_done for exactly 1 cycle. data_ok in
//   REQ/IDLE states is ignored (protocol error, not handled).
//  inst_stall = inst_req & ~i_done;  data_stall = data_req & ~d_done.
//  Latency: req in IDLE cycle 0, addr_ok in cycle 1, data_ok in cycle 2 -> done
//   and stall low in cycle 3; each extra bus wait cycle adds one.
//  Store: data_rdata undefined-but-stable (captured bus_rdata); done same timing.
//  flush: if high in IREQ/IWAIT, or in the same cycle IDLE launches IREQ, set
//   discard; the transaction completes on the bus, but i_done is suppressed and
//   inst_rdata is not updated; discard clears on return to IDLE. flush does not
//   touch data transactions (upstream gates data_req on exceptions).
//  Simultaneous inst_req & data_req in IDLE: data wins; fetch waits for both.
//  data_req arriving during an inst transaction waits; it is served next.
//  Back-to-back: same side re-issues at earliest the cycle after its done pulse.
// TESTING
//  1 load, addr_ok cyc1, data_ok cyc2, rdata=32'hDEADBEEF -> data_stall low cyc3, data_rdata=DEADBEEF
//  2 inst+data req same cycle -> bus_addr=data_addr first; inst served after d_done; inst_stall held throughout
//  3 sw sel=4'b0011 addr=0x80 wdata=0x1234 -> bus_wr=1, bus_sel=0011, fields stable until addr_ok (3 wait cycles)
//  4 flush during IWAIT -> data_ok arrives, no i_done, inst_rdata unchanged, next fetch issues normally
//  5 rst low while DWAIT -> all outputs 0 immediately, state IDLE, late data_ok ignored after release
//  6 10 back-to-back fetches, data_ok 0-3 wait cycles random -> every word delivered once, in order

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Single-port memory bus with a request/addr_ok/data_ok handshake.
// The arbiter is the master; the memory (or bench model) is the slave.
interface mem_bus_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic            req;
   logic            wr;
   logic [DW/8-1:0] sel;
   logic [AW-1:0]   addr;
   logic [DW-1:0]   wdata;
   logic            addr_ok;
   logic            data_ok;
   logic [DW-1:0]   rdata;

   modport master (
      output req, wr, sel, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, sel, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between instruction fetch and the mem stage.
// The data side has fixed priority and transactions are never pre-empted.
module mem_bus_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inst_req,
   input  logic [AW-1:0]   inst_addr,
   output logic [DW-1:0]   inst_rdata,
   output logic            inst_stall,
   input  logic            data_req,
   input  logic            data_wr,
   input  logic [DW/8-1:0] data_sel,
   input  logic [AW-1:0]   data_addr,
   input  logic [DW-1:0]   data_wdata,
   output logic [DW-1:0]   data_rdata,
   output logic            data_stall,
   input  logic            flush,
   mem_bus_arbiter_if.master bus
);

   typedef enum logic [2:0] {IDLE, DREQ, DWAIT, IREQ, IWAIT} state_t;

   state_t state, next_state;
   logic   d_done, i_done, discard;
   logic   data_elig, inst_elig;
   logic   launch_d, launch_i;
   logic   d_complete, i_complete, i_deliver;

   // A side sitting in its done cycle is not eligible, so a held request
   // is not re-served before the stage has advanced.
   assign data_elig  = data_req & ~d_done;
   assign inst_elig  = inst_req & ~i_done;
   assign launch_d   = (state == IDLE) & data_elig;
   assign launch_i   = (state == IDLE) & ~data_elig & inst_elig;
   assign d_complete = (state == DWAIT) & bus.data_ok;
   assign i_complete = (state == IWAIT) & bus.data_ok;
   assign i_deliver  = i_complete & ~discard & ~flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (launch_d)      next_state = DREQ;
            else if (launch_i) next_state = IREQ;
         end
         DREQ:    if (bus.addr_ok) next_state = DWAIT;
         DWAIT:   if (bus.data_ok) next_state = IDLE;
         IREQ:    if (bus.addr_ok) next_state = IWAIT;
         IWAIT:   if (bus.data_ok) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      bus.req = (state == DREQ) || (state == IREQ);
   end

   // Request fields are captured once at launch and held until the next launch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.wr    <= 1'b0;
         bus.sel   <= '0;
         bus.addr  <= '0;
         bus.wdata <= '0;
      end else if (launch_d) begin
         bus.wr    <= data_wr;
         bus.sel   <= data_sel;
         bus.addr  <= data_addr;
         bus.wdata <= data_wdata;
      end else if (launch_i) begin
         bus.wr    <= 1'b0;
         bus.sel   <= '1;
         bus.addr  <= inst_addr;
         bus.wdata <= '0;
      end
   end

   // A flushed fetch still drains on the bus but its result is dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         d_done     <= 1'b0;
         i_done     <= 1'b0;
         discard    <= 1'b0;
         data_rdata <= '0;
         inst_rdata <= '0;
      end else begin
         d_done <= d_complete;
         i_done <= i_deliver;
         if (d_complete) data_rdata <= bus.rdata;
         if (i_deliver)  inst_rdata <= bus.rdata;
         if (i_complete)
            discard <= 1'b0;
         else if (flush & (launch_i | (state == IREQ) | (state == IWAIT)))
            discard <= 1'b1;
      end
   end

   assign inst_stall = inst_req & ~i_done;
   assign data_stall = data_req & ~d_done;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: bus slave with random wait states, CPU-side drivers,
// and a transaction-level model compared against the outputs every cycle.
module tb_mem_bus_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req, data_req, data_wr, flush;
   logic [31:0] inst_addr, data_addr, data_wdata;
   logic [3:0]  data_sel;
   logic [31:0] inst_rdata, data_rdata;
   logic        inst_stall, data_stall;

   int n_checks = 0;
   int n_fails  = 0;

   mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bus_if ();

   mem_bus_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .inst_req   (inst_req),
      .inst_addr  (inst_addr),
      .inst_rdata (inst_rdata),
      .inst_stall (inst_stall),
      .data_req   (data_req),
      .data_wr    (data_wr),
      .data_sel   (data_sel),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .data_rdata (data_rdata),
      .data_stall (data_stall),
      .flush      (flush),
      .bus        (bus_if)
   );

   always #5 clk = ~clk;

   // Memory contents: every address holds a distinct word.
   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ 32'hDEADBEAF;
   endfunction

   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic exp);
      check_output(name, {31'b0, got}, {31'b0, exp});
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fails++;
      $display("[TB] FAIL %s: got no completion, expected done within cycle budget", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bus slave: addr_ok after a_cfg request cycles, data_ok d_cfg cycles
   // after acceptance; a negative setting picks 0..3 at random.
   int          a_cfg = 0;
   int          d_cfg = 0;
   int          s_phase = 0;
   int          s_cnt = -1;
   logic [31:0] s_addr;

   function automatic int pick(input int c);
      return (c < 0) ? int'($urandom_range(0, 3)) : c;
   endfunction

   initial begin
      bus_if.addr_ok = 1'b0;
      bus_if.data_ok = 1'b0;
      bus_if.rdata   = '0;
      forever begin
         tick();
         bus_if.addr_ok = 1'b0;
         bus_if.data_ok = 1'b0;
         bus_if.rdata   = $urandom;
         if (s_phase == 0) begin
            if (bus_if.req) begin
               if (s_cnt < 0) s_cnt = pick(a_cfg);
               if (s_cnt == 0) begin
                  bus_if.addr_ok = 1'b1;
                  s_addr  = bus_if.addr;
                  s_phase = 1;
                  s_cnt   = pick(d_cfg);
               end else begin
                  s_cnt--;
               end
            end
         end else if (s_cnt == 0) begin
            bus_if.data_ok = 1'b1;
            bus_if.rdata   = memf(s_addr);
            s_phase = 0;
            s_cnt   = -1;
         end else begin
            s_cnt--;
         end
      end
   end

   // Reference model: one outstanding transaction record plus the visible
   // result registers and one-cycle completion flags.
   bit          m_have, m_acc, m_is_data, m_disc, m_i_done, m_d_done;
   logic        m_wr;
   logic [3:0]  m_sel;
   logic [31:0] m_addr, m_wdata, m_inst_rdata, m_data_rdata;

   task automatic model_reset();
      m_have = 0; m_acc = 0; m_is_data = 0; m_disc = 0;
      m_i_done = 0; m_d_done = 0;
      m_wr = 0; m_sel = '0; m_addr = '0; m_wdata = '0;
      m_inst_rdata = '0; m_data_rdata = '0;
   endtask

   task automatic model_step();
      bit nd = 0;
      bit ni = 0;
      if (!m_have) begin
         if (data_req && !m_d_done) begin
            m_have = 1; m_acc = 0; m_is_data = 1; m_disc = 0;
            m_wr = data_wr; m_sel = data_sel; m_addr = data_addr; m_wdata = data_wdata;
         end else if (inst_req && !m_i_done) begin
            m_have = 1; m_acc = 0; m_is_data = 0; m_disc = flush;
            m_wr = 0; m_sel = 4'hF; m_addr = inst_addr;
         end
      end else begin
         if (!m_is_data && flush) m_disc = 1;
         if (!m_acc) begin
            if (bus_if.addr_ok) m_acc = 1;
         end else if (bus_if.data_ok) begin
            m_have = 0;
            if (m_is_data) begin
               m_data_rdata = bus_if.rdata;
               nd = 1;
            end else if (!m_disc) begin
               m_inst_rdata = bus_if.rdata;
               ni = 1;
            end
         end
      end
      m_d_done = nd;
      m_i_done = ni;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         model_reset();
      end else begin
         check_bit("bus_req", bus_if.req, m_have && !m_acc);
         if (m_have && !m_acc) begin
            check_output("bus_addr", bus_if.addr, m_addr);
            check_bit("bus_wr", bus_if.wr, m_wr);
            check_output("bus_sel", {28'b0, bus_if.sel}, {28'b0, m_sel});
            if (m_wr) check_output("bus_wdata", bus_if.wdata, m_wdata);
         end
         check_output("inst_rdata", inst_rdata, m_inst_rdata);
         check_output("data_rdata", data_rdata, m_data_rdata);
         check_bit("inst_stall", inst_stall, inst_req && !m_i_done);
         check_bit("data_stall", data_stall, data_req && !m_d_done);
         model_step();
      end
   end

   task automatic data_txn(input logic wr, input logic [3:0] sel, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat);
      bit timed_out = 0;
      data_req = 1'b1; data_wr = wr; data_sel = sel; data_addr = addr; data_wdata = wdata;
      lat = 0;
      forever begin
         @(negedge clk);
         if (!data_stall) break;
         lat++;
         if (lat > 200) begin
            timeout_fail("data_txn_timeout");
            timed_out = 1;
            break;
         end
      end
      if (!timed_out) check_output("data_word", data_rdata, memf(addr));
      tick();
      data_req = 1'b0;
   endtask

   task automatic inst_txn(input logic [31:0] addr, output int lat, output logic [31:0] rd);
      bit timed_out = 0;
      inst_req = 1'b1; inst_addr = addr;
      lat = 0;
      forever begin
         @(negedge clk);
         if (!inst_stall) break;
         lat++;
         if (lat > 300) begin
            timeout_fail("inst_txn_timeout");
            timed_out = 1;
            break;
         end
      end
      rd = inst_rdata;
      if (!timed_out) check_output("inst_word", rd, memf(addr));
      tick();
      inst_req = 1'b0;
   endtask

   initial begin
      #300000;
      timeout_fail("watchdog");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      int          lat, lat_d, lat_i, cyc;
      logic [31:0] rd;
      logic [31:0] got_q[$];
      bit          stop;

      rst = 1'b0; inst_req = 0; data_req = 0; data_wr = 0; flush = 0;
      inst_addr = '0; data_addr = '0; data_wdata = '0; data_sel = '0;
      model_reset();

      // Reset values, with stalls still following their requests
      repeat (2) tick();
      inst_req = 1'b1;
      #1;
      check_bit("rst_inst_stall", inst_stall, 1'b1);
      check_bit("rst_data_stall", data_stall, 1'b0);
      check_bit("rst_bus_req", bus_if.req, 1'b0);
      check_output("rst_bus_addr", bus_if.addr, 32'h0);
      check_output("rst_inst_rdata", inst_rdata, 32'h0);
      check_output("rst_data_rdata", data_rdata, 32'h0);
      inst_req = 1'b0;
      tick();
      rst = 1'b1;
      repeat (2) tick();

      $display("[TB] single load");
      a_cfg = 0; d_cfg = 0;
      data_txn(1'b0, 4'hF, 32'h40, 32'h0, lat);
      check_output("load_latency", 32'(lat), 32'd3);
      check_output("load_rdata", data_rdata, 32'hDEADBEEF);
      repeat (2) tick();

      $display("[TB] simultaneous inst and data request");
      fork
         data_txn(1'b0, 4'hF, 32'h300, 32'h0, lat_d);
         inst_txn(32'h400, lat_i, rd);
         begin
            @(negedge clk);
            @(negedge clk);
            check_bit("prio_req", bus_if.req, 1'b1);
            check_output("prio_addr", bus_if.addr, 32'h300);
         end
      join
      check_output("prio_data_latency", 32'(lat_d), 32'd3);
      check_output("prio_inst_latency", 32'(lat_i), 32'd6);
      repeat (2) tick();

      $display("[TB] store held through addr wait states");
      a_cfg = 3; d_cfg = 0;
      fork
         data_txn(1'b1, 4'b0011, 32'h80, 32'h1234, lat);
         begin
            @(negedge clk);
            repeat (4) begin
               @(negedge clk);
               check_bit("st_req", bus_if.req, 1'b1);
               check_bit("st_wr", bus_if.wr, 1'b1);
               check_output("st_sel", {28'b0, bus_if.sel}, 32'h3);
               check_output("st_addr", bus_if.addr, 32'h80);
               check_output("st_wdata", bus_if.wdata, 32'h1234);
            end
         end
      join
      check_output("st_latency", 32'(lat), 32'd6);
      repeat (2) tick();

      $display("[TB] flush during fetch wait");
      a_cfg = 0; d_cfg = 2;
      inst_req = 1'b1; inst_addr = 32'h100; cyc = 0;
      forever begin
         @(negedge clk);
         if (cyc == 5) check_output("flush_rdata_kept", inst_rdata, memf(32'h400));
         if (!inst_stall || cyc > 60) break;
         tick();
         cyc++;
         flush = (cyc == 2);
         if (cyc == 3) inst_addr = 32'h200;
      end
      check_output("flush_refetch_cycle", 32'(cyc), 32'd10);
      check_output("flush_refetch_word", inst_rdata, memf(32'h200));
      tick();
      inst_req = 1'b0; flush = 1'b0;
      repeat (2) tick();

      $display("[TB] reset during data wait");
      a_cfg = 0; d_cfg = 4;
      data_req = 1'b1; data_wr = 1'b0; data_sel = 4'hF; data_addr = 32'h500;
      tick();
      tick();
      #2 rst = 1'b0;
      #1;
      check_bit("arst_bus_req", bus_if.req, 1'b0);
      check_output("arst_bus_addr", bus_if.addr, 32'h0);
      check_output("arst_bus_sel", {28'b0, bus_if.sel}, 32'h0);
      check_output("arst_data_rdata", data_rdata, 32'h0);
      check_output("arst_inst_rdata", inst_rdata, 32'h0);
      check_bit("arst_data_stall", data_stall, 1'b1);
      data_req = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      repeat (4) tick();
      check_output("late_data_ok_rdata", data_rdata, 32'h0);
      check_bit("late_data_ok_req", bus_if.req, 1'b0);

      $display("[TB] back-to-back fetches");
      a_cfg = 0; d_cfg = -1;
      for (int i = 0; i < 10; i++) begin
         inst_txn(32'h1000 + 32'(4 * i), lat, rd);
         got_q.push_back(rd);
      end
      check_output("b2b_count", 32'(got_q.size()), 32'd10);
      for (int i = 0; i < got_q.size(); i++)
         check_output("b2b_order", got_q[i], memf(32'h1000 + 32'(4 * i)));
      repeat (2) tick();

      $display("[TB] random mixed traffic");
      a_cfg = -1; d_cfg = -1; stop = 0;
      fork
         begin
            fork
               for (int i = 0; i < 20; i++) begin
                  int l;
                  logic [31:0] r;
                  repeat ($urandom_range(0, 2)) tick();
                  inst_txn({22'b0, 8'($urandom_range(0, 255)), 2'b00}, l, r);
               end
               for (int j = 0; j < 20; j++) begin
                  int l;
                  repeat ($urandom_range(0, 2)) tick();
                  data_txn(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                           {22'b0, 8'($urandom_range(0, 255)), 2'b00}, $urandom, l);
               end
            join
            stop = 1;
         end
         begin
            while (!stop) begin
               tick();
               flush = ($urandom_range(0, 15) == 0);
            end
            flush = 1'b0;
         end
      join
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
